bcd_counter_multi: RTL and testbench

- Parametrised multi-digit BCD up/down counter with synchronous parallel load.
- Has a cascaded carry/borrow output and a time-multiplexed seven-segment display driver.
- Successor to the single-digit loadable BCD counter with display. It drives a DIGITS-wide common-anode/cathode display bank in the board top level.

---
 rtl/bcd_pkg.sv | 37 +++
 rtl/bcd_digit.sv | 34 +++
 rtl/bcd_counter_multi.sv | 116 +++++++++++
 tb/tb_bcd_counter_multi.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the seven-segment decode used by the multi-digit counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit up/down cell; the parent supplies an already-clamped load value
// and the cascade enable, and reads back the at-max/at-zero flags.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       cnt_in,
  input  logic       up,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_zero
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 4'd0;
    end else if (load) begin
      r_q <= ld_val;
    end else if (cnt_in) begin
      if (up) r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
      else    r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q       = r_q;
  assign at_max  = (r_q == BCD_MAX);
  assign at_zero = (r_q == 4'd0);

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with parallel load, wrap carry and a
// time-multiplexed seven-segment scan driver.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  load_err,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            disp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > BCD_MAX) ? 4'd0 : nib;
  endfunction

  logic [3:0]        w_digit [DIGITS];
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_cnt_in;
  logic [DIGITS-1:0] w_nib_err;
  logic [DIGITS:0]   w_chain_max;
  logic [DIGITS:0]   w_chain_zero;
  logic              w_step;

  logic              r_carry;
  logic              r_load_err;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_dig_idx;
  logic [DIGITS-1:0] r_an;
  logic [7:0]        r_disp;

  assign w_step = en & ~load;

  // chain[i] is true when every digit below i is at its wrap point.
  always_comb begin
    w_chain_max  = '0;
    w_chain_zero = '0;
    w_chain_max[0]  = 1'b1;
    w_chain_zero[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_chain_max[i+1]  = w_chain_max[i] & w_at_max[i];
      w_chain_zero[i+1] = w_chain_zero[i] & w_at_zero[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] w_ld_raw;
    logic [3:0] w_ld_val;
    assign w_ld_raw     = data[4*i +: 4];
    assign w_ld_val     = clamp_bcd(w_ld_raw);
    assign w_nib_err[i] = (w_ld_raw > BCD_MAX);
    assign w_cnt_in[i]  = w_step & (up ? w_chain_max[i] : w_chain_zero[i]);

    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .ld_val  (w_ld_val),
      .cnt_in  (w_cnt_in[i]),
      .up      (up),
      .q       (w_digit[i]),
      .at_max  (w_at_max[i]),
      .at_zero (w_at_zero[i])
    );

    assign count[4*i +: 4] = w_digit[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= w_step & (up ? w_chain_max[DIGITS] : w_chain_zero[DIGITS]);
      r_load_err <= load & (|w_nib_err);
    end
  end

  // Scan runs independently of load/en; the display registers lag index and count by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
      r_an       <= DIGITS'(1);
      r_disp     <= 8'h00;
    end else begin
      r_an   <= DIGITS'(1) << r_dig_idx;
      r_disp <= {1'b0, seg7(w_digit[r_dig_idx])};
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= (r_dig_idx == IDX_W'(DIGITS - 1)) ? '0 : r_dig_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  assign carry    = r_carry;
  assign load_err = r_load_err;
  assign an       = r_an;
  assign disp     = r_disp;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Randomized self-checking bench for bcd_counter_multi against an integer-valued reference model.
module tb_bcd_counter_multi;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int MODULUS  = 10000;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic        en;
  logic        up;
  logic [15:0] count;
  logic        carry;
  logic        load_err;
  logic [3:0]  an;
  logic [7:0]  disp;

  int n_checks;
  int n_errors;

  // Reference model state: decimal value, scan edges since reset, expected registered outputs.
  int         m_val;
  int         m_cyc;
  logic       m_carry;
  logic       m_err;
  logic [3:0] m_an;
  logic [7:0] m_disp;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_counter_multi #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .en       (en),
    .up       (up),
    .count    (count),
    .carry    (carry),
    .load_err (load_err),
    .an       (an),
    .disp     (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int digit_of(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  task automatic model_reset();
    m_val   = 0;
    m_cyc   = 0;
    m_carry = 1'b0;
    m_err   = 1'b0;
    m_an    = 4'b0001;
    m_disp  = 8'h00;
  endtask

  task automatic model_edge(input logic l, input logic [15:0] d, input logic e, input logic u);
    int idx;
    int nv;
    int p;
    idx    = (m_cyc / SCAN_DIV) % DIGITS;
    m_an   = 4'(1 << idx);
    m_disp = {1'b0, seg_tab[digit_of(m_val, idx)]};
    m_cyc++;
    m_carry = 1'b0;
    m_err   = 1'b0;
    if (l) begin
      nv = 0;
      p  = 1;
      for (int i = 0; i < DIGITS; i++) begin
        if (int'(d[4*i +: 4]) > 9) m_err = 1'b1;
        else nv = nv + p * int'(d[4*i +: 4]);
        p = p * 10;
      end
      m_val = nv;
    end else if (e) begin
      if (u) begin
        m_carry = (m_val == MODULUS - 1);
        m_val   = (m_val + 1) % MODULUS;
      end else begin
        m_carry = (m_val == 0);
        m_val   = (m_val + MODULUS - 1) % MODULUS;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},    32'(count),    32'(to_bcd(m_val)));
    chk({tag, ".carry"},    32'(carry),    32'(m_carry));
    chk({tag, ".load_err"}, 32'(load_err), 32'(m_err));
    chk({tag, ".an"},       32'(an),       32'(m_an));
    chk({tag, ".disp"},     32'(disp),     32'(m_disp));
  endtask

  task automatic step(input string tag, input logic l, input logic [15:0] d,
                      input logic e, input logic u);
    load = l;
    data = d;
    en   = e;
    up   = u;
    @(posedge clk);
    model_edge(l, d, e, u);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] rd;
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    load = 1'b0;
    data = '0;
    en   = 1'b0;
    up   = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    step("ld0095", 1'b1, 16'h0095, 1'b0, 1'b1);
    chk("ld0095.direct", 32'(count), 32'h0095);
    step("up0096", 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("up0096.direct", 32'(count), 32'h0096);

    step("ld9998", 1'b1, 16'h9998, 1'b0, 1'b1);
    step("up9999", 1'b0, 16'h0000, 1'b1, 1'b1);
    step("wrapup", 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("wrapup.carry_direct", 32'(carry), 32'h1);
    step("up0001", 1'b0, 16'h0000, 1'b1, 1'b1);

    step("ld0001", 1'b1, 16'h0001, 1'b0, 1'b0);
    step("dn0000", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("wrapdn", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("wrapdn.count_direct", 32'(count), 32'h9999);
    step("dn9998", 1'b0, 16'h0000, 1'b1, 1'b0);

    step("ld1A3F", 1'b1, 16'h1A3F, 1'b0, 1'b1);
    chk("ld1A3F.direct", 32'(count), 32'h1030);
    step("ldprio", 1'b1, 16'h0005, 1'b1, 1'b1);
    chk("ldprio.direct", 32'(count), 32'h0005);

    step("ld4321", 1'b1, 16'h4321, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("hold", 1'b0, 16'h0000, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'h9997;
        1:       rd = 16'h0002;
        default: rd = 16'($urandom);
      endcase
      step("rand", ($urandom_range(0, 9) == 0), rd,
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    step("pre_rst_ld", 1'b1, 16'h0458, 1'b0, 1'b1);
    step("pre_rst_up", 1'b0, 16'h0000, 1'b1, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step("post_rst", 1'b0, 16'h0000, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
